// File: rtl/key_encoder.sv
// rtl/key_encoder.sv - debounced 16-key encoder with single-entry code holding register
// Optional sticky lost-key flag: define KEY_ENCODER_OVERRUN_EN to add the overrun port.
module key_encoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [15:0] key_in,
  input  logic        key_ack,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_busy
`ifdef KEY_ENCODER_OVERRUN_EN
  ,
  output logic        overrun
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_WAIT_REL  = 2'd2,
    ST_DEB_REL   = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

  // Lowest set bit wins when several keys are down at once.
  function automatic logic [3:0] enc(input logic [15:0] v);
    enc = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) enc = 4'(i);
    end
  endfunction

  logic [15:0] sync1_q, ks_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        ack_ok;
  logic        ks_any;
  logic [3:0]  ks_code;

  assign ks_any  = |ks_q;
  assign ks_code = enc(ks_q);
  assign ack_ok  = key_ack && valid_q;

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 16'h0000;
      ks_q    <= 16'h0000;
    end else begin
      sync1_q <= key_in;
      ks_q    <= sync1_q;
    end
  end

  // Debounce FSM next state; a non-input mode parks everything in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (mode != 2'd0) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ks_any) begin
            cand_d  = ks_code;
            cnt_d   = 16'd0;
            state_d = ST_DEB_PRESS;
          end
        end
        ST_DEB_PRESS: begin
          if (!ks_any || (ks_code != cand_q)) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            state_d = ST_WAIT_REL;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_WAIT_REL: begin
          if (!ks_any) begin
            cnt_d   = 16'd0;
            state_d = ST_DEB_REL;
          end
        end
        ST_DEB_REL: begin
          if (ks_any) begin
            state_d = ST_WAIT_REL;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Holding register: a pending code is never overwritten unless acked on the same edge.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    if (mode != 2'd0) begin
      valid_d = 1'b0;
    end else if (accept) begin
      if (!valid_q || key_ack) begin
        code_d  = cand_q;
        valid_d = 1'b1;
      end
    end else if (ack_ok) begin
      valid_d = 1'b0;
    end
  end

  // Register FSM state, counter, candidate and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      cand_q  <= 4'h0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_busy  = busy_q;

`ifdef KEY_ENCODER_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic drop;

  assign drop = accept && valid_q && !key_ack;

  // Sticky lost-key flag, cleared only when the consumer takes the pending code.
  always_comb begin
    ovr_d = ovr_q;
    if (drop)   ovr_d = 1'b1;
    if (ack_ok) ovr_d = 1'b0;
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`endif

endmodule

// File: tb/tb_key_encoder.sv
// tb/tb_key_encoder.sv - self-checking bench for key_encoder with a streak-counting reference model
module tb_key_encoder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] key_in = 16'h0000;
  logic        key_ack = 1'b0;
  logic [3:0]  key_code, key_code1;
  logic        key_valid, key_valid1;
  logic        key_busy, key_busy1;
`ifdef KEY_ENCODER_OVERRUN_EN
  logic        overrun, overrun1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  key_encoder #(.DEBOUNCE_CYCLES(16'd4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key_in(key_in), .key_ack(key_ack),
    .key_code(key_code), .key_valid(key_valid), .key_busy(key_busy)
`ifdef KEY_ENCODER_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  key_encoder #(.DEBOUNCE_CYCLES(16'd1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key_in(key_in), .key_ack(key_ack),
    .key_code(key_code1), .key_valid(key_valid1), .key_busy(key_busy1)
`ifdef KEY_ENCODER_OVERRUN_EN
    , .overrun(overrun1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowbit(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: a press is taken after D+1 consecutive synchronized samples of the
  // same code while armed; re-arming needs D+1 consecutive all-released samples.
  logic [15:0] hist[$];
  bit armed;
  int streak, scode, rel;
  int m_valid, m_code, m_ovr, m_busy;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] ks;
    bit acc, ack_ok;
    if (!rst_n) begin
      hist.delete();
      armed = 1'b1; streak = 0; scode = 0; rel = 0;
      m_valid = 0; m_code = 0; m_ovr = 0; m_busy = 0;
    end else begin
      ks = (hist.size() >= 2) ? hist[hist.size() - 2] : 16'h0000;
      hist.push_back(key_in);
      if (hist.size() > 3) void'(hist.pop_front());
      acc = 1'b0;
      if (mode != 2'd0) begin
        armed = 1'b1; streak = 0; rel = 0;
      end else if (armed) begin
        if (streak == 0) begin
          if (ks != 16'h0000) begin streak = 1; scode = lowbit(ks); end
        end else if (ks != 16'h0000 && lowbit(ks) == scode) begin
          streak++;
        end else begin
          streak = 0;
        end
        if (streak == D + 1) begin acc = 1'b1; armed = 1'b0; streak = 0; rel = 0; end
      end else begin
        if (ks == 16'h0000) rel++; else rel = 0;
        if (rel == D + 1) begin armed = 1'b1; rel = 0; end
      end
      ack_ok = key_ack && (m_valid != 0);
      if (mode != 2'd0) m_valid = 0;
      else if (acc && m_valid != 0 && !key_ack) m_ovr = 1;
      else if (acc) begin m_valid = 1; m_code = scode; end
      else if (ack_ok) m_valid = 0;
      if (ack_ok) m_ovr = 0;
      m_busy = (!armed || streak > 0) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", 32'(key_valid), 32'(m_valid));
      chk("model_code",  32'(key_code),  32'(m_code));
      chk("model_busy",  32'(key_busy),  32'(m_busy));
`ifdef KEY_ENCODER_OVERRUN_EN
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  initial begin
    int rises;
    logic prev;

    cyc(2);
    chk("reset_valid", 32'(key_valid), 32'h0);
    chk("reset_code",  32'(key_code),  32'h0);
    chk("reset_busy",  32'(key_busy),  32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc(3);

    // Single key, latency D+3, busy from edge 3; D=1 instance accepts at edge 4.
    key_in = 16'h0020;
    cyc(2); chk("lat_busy_e2", 32'(key_busy), 32'h0);
    cyc(1); chk("lat_busy_e3", 32'(key_busy), 32'h1);
    chk("d1_valid_e3", 32'(key_valid1), 32'h0);
    cyc(1); chk("d1_valid_e4", 32'(key_valid1), 32'h1);
    chk("d1_code_e4", 32'(key_code1), 32'h5);
    cyc(2); chk("lat_valid_e6", 32'(key_valid), 32'h0);
    cyc(1); chk("lat_valid_e7", 32'(key_valid), 32'h1);
    chk("lat_code", 32'(key_code), 32'h5);
    cyc(5);
    key_in = 16'h0000;
    ack_pulse();
    chk("ack_clears", 32'(key_valid), 32'h0);
    cyc(10);

    // Bounce on key 5, then key 6 steady.
    key_in = 16'h0020; cyc(2);
    key_in = 16'h0000; cyc(2);
    key_in = 16'h0040; cyc(12);
    chk("bounce_valid", 32'(key_valid), 32'h1);
    chk("bounce_code",  32'(key_code),  32'h6);
    key_in = 16'h0000;
    ack_pulse();
    cyc(10);

    // Two keys down: lowest wins; long hold produces one code.
    key_in = 16'h8010;
    rises = 0;
    prev = key_valid;
    for (int i = 0; i < 50; i++) begin
      key_ack = (i % 5 == 4);
      cyc(1);
      if (key_valid && !prev) rises++;
      prev = key_valid;
    end
    key_ack = 1'b0;
    chk("hold_one_code", 32'(rises), 32'd1);
    chk("multi_code", 32'(key_code), 32'h4);
    key_in = 16'h0000;
    cyc(10);

    // Overrun: second key while first still pending.
    key_in = 16'h0002; cyc(10);
    key_in = 16'h0000; cyc(10);
    key_in = 16'h0004; cyc(10);
    chk("ovr_code_kept",  32'(key_code),  32'h1);
    chk("ovr_valid_kept", 32'(key_valid), 32'h1);
`ifdef KEY_ENCODER_OVERRUN_EN
    chk("ovr_set", 32'(overrun), 32'h1);
`endif
    ack_pulse();
    chk("ovr_ack_valid", 32'(key_valid), 32'h0);
`ifdef KEY_ENCODER_OVERRUN_EN
    chk("ovr_cleared", 32'(overrun), 32'h0);
`endif
    key_in = 16'h0000;
    cyc(10);

    // Accept and ack on the same edge: new code replaces the old one.
    key_in = 16'h0002; cyc(10);
    key_in = 16'h0000; cyc(10);
    key_in = 16'h0008; cyc(6);
    ack_pulse();
    chk("same_edge_valid", 32'(key_valid), 32'h1);
    chk("same_edge_code",  32'(key_code),  32'h3);
`ifdef KEY_ENCODER_OVERRUN_EN
    chk("same_edge_no_ovr", 32'(overrun), 32'h0);
`endif
    ack_pulse();
    key_in = 16'h0000;
    cyc(10);

    // Mode change during debounce, then re-debounce of the held key.
    key_in = 16'h0100; cyc(4);
    mode = 2'd1; cyc(1);
    chk("mode_busy_low", 32'(key_busy), 32'h0);
    cyc(4);
    chk("mode_no_valid", 32'(key_valid), 32'h0);
    mode = 2'd0; cyc(4);
    chk("redeb_e4", 32'(key_valid), 32'h0);
    cyc(1);
    chk("redeb_e5", 32'(key_valid), 32'h1);
    chk("redeb_code", 32'(key_code), 32'h8);
    mode = 2'd2; cyc(1);
    chk("mode_clears_valid", 32'(key_valid), 32'h0);
    chk("mode_holds_code", 32'(key_code), 32'h8);
    mode = 2'd0;
    key_in = 16'h0000;
    cyc(10);

    // Asynchronous reset with a key pending; held key accepted afresh.
    key_in = 16'h0200; cyc(9);
    chk("pre_rst_valid", 32'(key_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(key_valid), 32'h0);
    chk("async_rst_code",  32'(key_code),  32'h0);
    chk("async_rst_busy",  32'(key_busy),  32'h0);
`ifdef KEY_ENCODER_OVERRUN_EN
    chk("async_rst_ovr", 32'(overrun), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    chk("post_rst_e6", 32'(key_valid), 32'h0);
    cyc(1);
    chk("post_rst_e7", 32'(key_valid), 32'h1);
    chk("post_rst_code", 32'(key_code), 32'h9);
    key_in = 16'h0000;
    ack_pulse();
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16'd1000, legal range 1..65535; number of consecutive stable cycles required to accept a press or a release.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mode  input  2  0=input, 1=run, 2=debug; scanning is active only in mode 0.
REQ-005 key_in  input  16  raw key lines, bit i = key i pressed; asynchronous to clk.
REQ-006 key_ack  input  1  consumer acknowledge of the pending key.
REQ-007 key_code  output  4  code of the pending key (index of the key bit).
REQ-008 key_valid  output  1  a key code is pending.
REQ-009 key_busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 overrun  output  1  sticky lost-key flag; present only with KEY_ENCODER_OVERRUN_EN.

Function
REQ-011 key_in shall pass through a 2-flop synchronizer; all logic below uses the synchronized value ks.
REQ-012 enc(ks) shall be the index of the lowest set bit of ks (e.g. 16'h8010 -> 4); ks==0 means "none".
REQ-013 FSM states: IDLE, DEB_PRESS, WAIT_REL, DEB_REL; a 16-bit counter cnt.
REQ-014 IDLE: ks!=0 -> latch cand=enc(ks), cnt=0, go DEB_PRESS.
REQ-015 DEB_PRESS: ks==0 or enc(ks)!=cand -> IDLE; else cnt++; on the cycle with cnt==DEBOUNCE_CYCLES-1, accept cand and go WAIT_REL.
REQ-016 Latency: with key_in stable, key_valid shall be high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new key_in.
REQ-017 Accept: key_code<=cand, key_valid<=1 (single-entry holding register, independent of FSM).
REQ-018 WAIT_REL: ks==0 -> cnt=0, go DEB_REL; else stay (held key never re-accepted).
REQ-019 DEB_REL: ks!=0 -> WAIT_REL; else cnt++; at cnt==DEBOUNCE_CYCLES-1 go IDLE.
REQ-020 key_ack sampled high while key_valid=1 shall clear key_valid at that edge; key_ack while key_valid=0 is ignored.
REQ-021 Accept while key_valid=1 and key_ack=0: new code dropped, key_code/key_valid unchanged (overrun event).
REQ-022 Accept and key_ack on the same edge: new code loaded, key_valid stays 1, no overrun event.
REQ-023 mode!=0: FSM forced to IDLE, cnt=0, key_valid cleared, key_code held; resume from IDLE when mode returns to 0.
REQ-024 cnt shall never wrap; DEBOUNCE_CYCLES=1 accepts on the first DEB_PRESS cycle.

Reset
REQ-025 rst_n low shall immediately force: state=IDLE, cnt=0, synchronizer flops=0, key_code=4'h0, key_valid=0, key_busy=0, overrun=0.
REQ-026 Reset asserted mid-debounce or with a key pending shall discard all progress; after release a still-held key is debounced afresh from IDLE.

Configuration
REQ-027 Macro KEY_ENCODER_OVERRUN_EN defined: overrun port exists, set on any REQ-021 event, cleared only by key_ack accepted (REQ-020) or reset; mode!=0 does not clear it.
REQ-028 Macro KEY_ENCODER_OVERRUN_EN undefined: no overrun port or logic; REQ-021 drops silently; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 key_in=16'h0020 held 12 cycles -> key_valid rises 7 edges after first sampling edge, key_code=4'h5, key_busy high from edge 3.
REQ-030 key_in=16'h0020 for 2 cycles then 0, then 16'h0040 steady -> no valid for key 5; key_code=4'h6 accepted.
REQ-031 key_in=16'h8010 steady -> key_code=4'h4; held 50 cycles with key_ack pulses -> exactly one key_valid.
REQ-032 Accept key 1, no ack, release, press key 2 -> key_code stays 4'h1, overrun=1 (if EN); then key_ack -> key_valid=0, overrun=0.
REQ-033 mode=1 asserted during DEB_PRESS -> key_busy=0 next edge, no key_valid; mode=0 with key held -> full DEBOUNCE_CYCLES+1 re-debounce.
REQ-034 rst_n pulsed low with key_valid=1 during WAIT_REL -> all outputs 0 asynchronously; held key re-accepted after 7 edges.
